// File: rtl/pipelined_adder.sv
// Carry-chained adder/subtractor split into WIDTH/CHUNK register stages.
// Each stage adds one CHUNK-wide slice and passes its carry to the next stage.
module pipelined_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / CHUNK;

    // Handshake: a beat moves when valid && ready in the same cycle. The whole
    // pipeline freezes while the last stage holds a result nobody takes, so
    // in_ready depends only on that stall (and on reset).
    logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
    logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
    logic [STAGES-1:0][WIDTH-1:0] s_q, s_d;
    logic [STAGES-1:0]            c_q, c_d;
    logic [STAGES-1:0]            v_q, v_d;

    logic [STAGES-1:0][WIDTH-1:0] a_src;
    logic [STAGES-1:0][WIDTH-1:0] b_src;
    logic [STAGES-1:0][WIDTH-1:0] s_src;
    logic [STAGES-1:0]            c_src;
    logic [STAGES-1:0]            v_src;

    logic             stall;
    logic             accept;
    logic [WIDTH-1:0] b_op;
    logic             c0;
    logic [CHUNK:0]   part;

    assign stall    = v_q[STAGES-1] && !out_ready;
    assign in_ready = !stall && !rst;
    assign accept   = in_valid && in_ready;
    assign b_op     = sub ? ~in2 : in2;
    assign c0       = sub | cin;

    // Stage k reads the fresh operands (k=0) or the register of stage k-1.
    always_comb begin
        a_src[0] = in1;
        b_src[0] = b_op;
        s_src[0] = '0;
        c_src[0] = c0;
        v_src[0] = accept;
        for (int k = 1; k < STAGES; k++) begin
            a_src[k] = a_q[k-1];
            b_src[k] = b_q[k-1];
            s_src[k] = s_q[k-1];
            c_src[k] = c_q[k-1];
            v_src[k] = v_q[k-1];
        end
    end

    always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        s_d  = s_q;
        c_d  = c_q;
        v_d  = v_q;
        part = '0;
        if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                part = {1'b0, a_src[k][k*CHUNK +: CHUNK]}
                     + {1'b0, b_src[k][k*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, c_src[k]};
                a_d[k] = a_src[k];
                b_d[k] = b_src[k];
                s_d[k] = s_src[k];
                s_d[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
                c_d[k] = part[CHUNK];
                v_d[k] = v_src[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            s_q <= '0;
            c_q <= '0;
            v_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            s_q <= s_d;
            c_q <= c_d;
            v_q <= v_d;
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    // Operand signs ride to the end of the pipe only to form the overflow flag.
    assign ovf       = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1])
                    && (s_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);

    logic unused_low_operand_bits;
    assign unused_low_operand_bits = ^{a_q[STAGES-1][WIDTH-2:0], b_q[STAGES-1][WIDTH-2:0]};

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, bits added per pipeline stage; WIDTH SHALL be a multiple of CHUNK, and STAGES = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand beat present.
REQ-006 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-007 SHALL have port in1  input  WIDTH  first operand.
REQ-008 SHALL have port in2  input  WIDTH  second operand.
REQ-009 SHALL have port cin  input  1  carry-in, used when sub=0.
REQ-010 SHALL have port sub  input  1  0 = add, 1 = subtract.
REQ-011 SHALL have port out_valid  output  1  result beat present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port sum  output  WIDTH  result.
REQ-014 SHALL have port cout  output  1  carry-out (sub: 1 = no borrow).
REQ-015 SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-016 SHALL accept a beat when in_valid && in_ready, sampling in1, in2, cin and sub together.
REQ-017 SHALL form operand B = sub ? ~in2 : in2 and carry-in C0 = sub ? 1 : cin; cin is ignored when sub=1.
REQ-018 SHALL compute, in stage k (k=0..STAGES-1), chunk k of in1 + B, using carry-in C0 for k=0 and the registered carry of stage k-1 otherwise.
REQ-019 SHALL delay the unused higher operand chunks and the finished lower sum chunks alongside each beat, so that every beat stays aligned.
REQ-020 SHALL present the result exactly STAGES cycles after acceptance when no stall occurs (latency 4 at defaults), with full throughput of one beat per cycle.
REQ-021 SHALL give sum = (in1 + B + C0) mod 2^WIDTH and cout = the carry out of bit WIDTH-1.
REQ-022 SHALL set ovf = (in1[MSB] == B[MSB]) && (sum[MSB] != in1[MSB]).
REQ-023 SHALL carry a valid bit per stage, so that bubbles propagate and never produce out_valid.
REQ-024 SHALL define stall = out_valid && !out_ready; while stalled, all stage registers and outputs SHALL hold.
REQ-025 SHALL drive in_ready = !stall && !rst, a combinational function of the stall condition.
REQ-026 SHALL hold sum, cout and ovf stable while out_valid=1 and out_ready=0.
REQ-027 SHALL complete out_valid && out_ready in the same cycle as a new beat arrives in the last stage, with no bubble inserted.
REQ-028 SHALL produce identical results for every CHUNK that divides WIDTH, including CHUNK=WIDTH (STAGES=1, latency 1).

Reset
REQ-029 SHALL, on a rising edge with rst=1, clear every stage valid bit and drive out_valid=0, sum=0, cout=0 and ovf=0.
REQ-030 SHALL drive in_ready=0 while rst=1 and accept no beat in that cycle.
REQ-031 SHALL discard all in-flight beats when rst is asserted mid-operation; none SHALL appear after reset deasserts.
REQ-032 SHALL allow in_ready to go to 1 in the first cycle after rst deasserts.

Verification (WIDTH=32, CHUNK=8)
REQ-033 SHALL cover the add with carry chain: in1=0xFFFFFFFF, in2=0x00000000, cin=1, sub=0 -> after 4 cycles sum=0x00000000, cout=1, ovf=0.
REQ-034 SHALL cover subtract with borrow: in1=5, in2=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0; and in1=0x80000000, in2=1, sub=1 -> sum=0x7FFFFFFF, ovf=1, cout=1.
REQ-035 SHALL cover signed add overflow: in1=0x7FFFFFFF, in2=1, cin=0 -> sum=0x80000000, ovf=1, cout=0.
REQ-036 SHALL cover streaming with backpressure: 8 back-to-back beats with out_ready low on cycles 6-8 -> in_ready low while stalled, outputs held, all 8 results returned in order with none lost or duplicated.
REQ-037 SHALL cover reset mid-stream: 3 beats in flight, rst pulsed for 1 cycle -> out_valid=0, sum=0, and no stale results after release.
REQ-038 SHALL cover bubbles and randomisation: random operands with random in_valid and out_ready over 10k beats, checked against a reference model; also rerun with CHUNK=4 and CHUNK=32 and check latency 8 and 1 respectively.
